// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the hazard-gated control bits, the ID-stage operands and the
// register specifiers. They are presented to EX one cycle later. Each entry
// carries a valid bit. The register supports hold (stall), flush and bubble
// insertion. Optionally, a saturating bubble counter supports CPI measurement.
//
// Per-edge priority: rst_i > flush_i > stall_i > load.
//
// Configuration macro: IDEX_BUBBLE_CNT_EN
//    defined   -> CNT_W parameter, bubble counter flops and bubble_cnt_o exist
//    undefined -> no counter, no bubble_cnt_o port; all else identical
//
// Ports:
//    clk_i, rst_i            clock (rising edge), async active-high reset
//    stall_i                 hold every stored field and valid_o
//    flush_i                 replace the entry with an all-zero bubble
//    bubble_i                incoming entry is a bubble: control zeroed, not valid
//    RegDst_i .. MemRead_i   1-bit control bits (already gated upstream)
//    ALUOp_i                 ALU operation class, ALUOP_W bits
//    RSdata_i, RTdata_i      operands, DATA_W bits
//    SignExt_i               sign-extended immediate, DATA_W bits
//    RSaddr_i..RDaddr_i      5-bit register specifiers
//    *_o                     registered copies of the fields above
//    valid_o                 entry holds a real instruction
//    bubble_cnt_o            non-valid entries inserted (macro only)
// -----------------------------------------------------------------------------
module id_ex_reg #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 2
`ifdef IDEX_BUBBLE_CNT_EN
   ,
   parameter int CNT_W   = 16
`endif
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               bubble_i,
   input  logic               RegDst_i,
   input  logic               ALUSrc_i,
   input  logic               RegWrite_i,
   input  logic               MemToReg_i,
   input  logic               MemWrite_i,
   input  logic               MemRead_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [DATA_W-1:0]  RSdata_i,
   input  logic [DATA_W-1:0]  RTdata_i,
   input  logic [DATA_W-1:0]  SignExt_i,
   input  logic [4:0]         RSaddr_i,
   input  logic [4:0]         RTaddr_i,
   input  logic [4:0]         RDaddr_i,
   output logic               RegDst_o,
   output logic               ALUSrc_o,
   output logic               RegWrite_o,
   output logic               MemToReg_o,
   output logic               MemWrite_o,
   output logic               MemRead_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic [DATA_W-1:0]  RSdata_o,
   output logic [DATA_W-1:0]  RTdata_o,
   output logic [DATA_W-1:0]  SignExt_o,
   output logic [4:0]         RSaddr_o,
   output logic [4:0]         RTaddr_o,
   output logic [4:0]         RDaddr_o,
   output logic               valid_o
`ifdef IDEX_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0]   bubble_cnt_o
`endif
);

   // Control bits are forced to zero for a bubble so that a non-valid entry
   // can never write the register file or memory downstream.
   logic keep_ctrl;
   assign keep_ctrl = ~bubble_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || flush_i) begin
         RegDst_o   <= 1'b0;
         ALUSrc_o   <= 1'b0;
         RegWrite_o <= 1'b0;
         MemToReg_o <= 1'b0;
         MemWrite_o <= 1'b0;
         MemRead_o  <= 1'b0;
         ALUOp_o    <= '0;
         RSdata_o   <= '0;
         RTdata_o   <= '0;
         SignExt_o  <= '0;
         RSaddr_o   <= '0;
         RTaddr_o   <= '0;
         RDaddr_o   <= '0;
         valid_o    <= 1'b0;
      end else if (!stall_i) begin
         RegDst_o   <= RegDst_i   & keep_ctrl;
         ALUSrc_o   <= ALUSrc_i   & keep_ctrl;
         RegWrite_o <= RegWrite_i & keep_ctrl;
         MemToReg_o <= MemToReg_i & keep_ctrl;
         MemWrite_o <= MemWrite_i & keep_ctrl;
         MemRead_o  <= MemRead_i  & keep_ctrl;
         ALUOp_o    <= ALUOp_i & {ALUOP_W{keep_ctrl}};
         // Data and addresses load even for a bubble.
         RSdata_o   <= RSdata_i;
         RTdata_o   <= RTdata_i;
         SignExt_o  <= SignExt_i;
         RSaddr_o   <= RSaddr_i;
         RTaddr_o   <= RTaddr_i;
         RDaddr_o   <= RDaddr_i;
         valid_o    <= keep_ctrl;
      end
   end

`ifdef IDEX_BUBBLE_CNT_EN
   // Count every edge that installs a non-valid entry: a flush (even while
   // stalled) or an unstalled load of a bubble. Saturates at all-ones.
   logic bubble_event;
   assign bubble_event = flush_i | (~stall_i & bubble_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_o <= '0;
      end else if (bubble_event && (bubble_cnt_o != {CNT_W{1'b1}})) begin
         bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg -- directed, self-checking bench for id_ex_reg.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Counter checks are present only with IDEX_BUBBLE_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_reg;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, flush_i, bubble_i;
   logic        RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, MemRead_i;
   logic [1:0]  ALUOp_i;
   logic [31:0] RSdata_i, RTdata_i, SignExt_i;
   logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
   logic        RegDst_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemWrite_o, MemRead_o;
   logic [1:0]  ALUOp_o;
   logic [31:0] RSdata_o, RTdata_o, SignExt_o;
   logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
   logic        valid_o;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [3:0]  bubble_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   id_ex_reg #(
      .DATA_W(32),
      .ALUOP_W(2)
`ifdef IDEX_BUBBLE_CNT_EN
      ,
      .CNT_W(4)
`endif
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .bubble_i(bubble_i),
      .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
      .MemToReg_i(MemToReg_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
      .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
      .SignExt_i(SignExt_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
      .RDaddr_i(RDaddr_i),
      .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
      .MemToReg_o(MemToReg_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
      .ALUOp_o(ALUOp_o), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
      .SignExt_o(SignExt_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
      .RDaddr_o(RDaddr_o), .valid_o(valid_o)
`ifdef IDEX_BUBBLE_CNT_EN
      ,
      .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic cnt_check(input string tag, input int exp);
`ifdef IDEX_BUBBLE_CNT_EN
      check(tag, 64'(bubble_cnt_o), 64'(exp));
`endif
   endtask

   // Drive on the falling edge.
   task automatic drive_fields(input logic [5:0] ctrl, input logic [1:0] aluop,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] se, input logic [4:0] ra,
                               input logic [4:0] ta, input logic [4:0] da);
      @(negedge clk_i);
      {RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, MemRead_i} = ctrl;
      ALUOp_i = aluop; RSdata_i = rs; RTdata_i = rt; SignExt_i = se;
      RSaddr_i = ra; RTaddr_i = ta; RDaddr_i = da;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
      {RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, MemRead_i} = '0;
      ALUOp_i = '0; RSdata_i = '0; RTdata_i = '0; SignExt_i = '0;
      RSaddr_i = '0; RTaddr_i = '0; RDaddr_i = '0;
      step(); step();
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_rsdata", 64'(RSdata_o), 64'd0);
      cnt_check("rst_cnt", 0);

      // First load after release: the very first edge with rst_i low loads.
      drive_fields(6'b111111, 2'b01, 32'h12345678, 32'hAAAA5555, 32'h0000_0004, 5'd1, 5'd2, 5'd7);
      rst_i = 1'b0;
      step();
      check("load_rsdata", 64'(RSdata_o), 64'h12345678);
      check("load_regwrite", 64'(RegWrite_o), 64'd1);
      check("load_valid", 64'(valid_o), 64'd1);
      check("load_rdaddr", 64'(RDaddr_o), 64'd7);
      check("load_aluop", 64'(ALUOp_o), 64'd1);

      // Asynchronous reset between edges while stalled with a valid entry.
      @(negedge clk_i);
      stall_i = 1'b1;
      rst_i = 1'b1;
      #1;
      check("arst_rsdata", 64'(RSdata_o), 64'd0);
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_regwrite", 64'(RegWrite_o), 64'd0);
      step();
      check("arst_hold_valid", 64'(valid_o), 64'd0);
      drive_fields(6'b001000, 2'b00, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      stall_i = 1'b0;
      rst_i = 1'b0;
      step();
      check("rel_rsdata", 64'(RSdata_o), 64'h12345678);
      check("rel_regwrite", 64'(RegWrite_o), 64'd1);
      check("rel_valid", 64'(valid_o), 64'd1);

      // Bubble: control zeroed, data loads, not valid, counter +1.
      drive_fields(6'b001010, 2'b10, 32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 5'd9);
      bubble_i = 1'b1;
      step();
      check("bub_regwrite", 64'(RegWrite_o), 64'd0);
      check("bub_memwrite", 64'(MemWrite_o), 64'd0);
      check("bub_aluop", 64'(ALUOp_o), 64'd0);
      check("bub_rtdata", 64'(RTdata_o), 64'hDEADBEEF);
      check("bub_rdaddr", 64'(RDaddr_o), 64'd9);
      check("bub_valid", 64'(valid_o), 64'd0);
      cnt_check("bub_cnt", 1);

      // Entry A.
      drive_fields(6'b111111, 2'b11, 32'h11111111, 32'h22222222, 32'hFFFF8000, 5'd1, 5'd2, 5'd3);
      bubble_i = 1'b0;
      step();
      check("A_valid", 64'(valid_o), 64'd1);
      check("A_memread", 64'(MemRead_o), 64'd1);
      check("A_signext", 64'(SignExt_o), 64'hFFFF8000);

      // Three stalled cycles with changing inputs (bubble_i ignored).
      for (int i = 0; i < 3; i++) begin
         drive_fields(6'b000000, 2'b00, 32'h100 + i, 32'h200 + i, 32'h0, 5'd30, 5'd30, 5'd30);
         stall_i = 1'b1;
         bubble_i = (i == 1);
         step();
         check($sformatf("stall%0d_rsdata", i), 64'(RSdata_o), 64'h11111111);
         check($sformatf("stall%0d_rdaddr", i), 64'(RDaddr_o), 64'd3);
         check($sformatf("stall%0d_valid", i), 64'(valid_o), 64'd1);
         check($sformatf("stall%0d_regwrite", i), 64'(RegWrite_o), 64'd1);
         cnt_check($sformatf("stall%0d_cnt", i), 1);
      end

      // Stall drops: current inputs load.
      drive_fields(6'b100000, 2'b01, 32'h33333333, 32'h44444444, 32'h5, 5'd4, 5'd5, 5'd6);
      stall_i = 1'b0;
      bubble_i = 1'b0;
      step();
      check("post_rsdata", 64'(RSdata_o), 64'h33333333);
      check("post_regdst", 64'(RegDst_o), 64'd1);
      check("post_regwrite", 64'(RegWrite_o), 64'd0);
      check("post_valid", 64'(valid_o), 64'd1);
      cnt_check("post_cnt", 1);

      // Flush beats stall.
      drive_fields(6'b111111, 2'b11, 32'h55555555, 32'h66666666, 32'h7, 5'd8, 5'd9, 5'd10);
      stall_i = 1'b1;
      flush_i = 1'b1;
      step();
      check("fl_rsdata", 64'(RSdata_o), 64'd0);
      check("fl_rdaddr", 64'(RDaddr_o), 64'd0);
      check("fl_regdst", 64'(RegDst_o), 64'd0);
      check("fl_valid", 64'(valid_o), 64'd0);
      cnt_check("fl_cnt", 2);

      // Saturation: clear the counter, then 20 consecutive flushes.
      @(negedge clk_i);
      stall_i = 1'b0;
      flush_i = 1'b0;
      rst_i = 1'b1;
      step();
      @(negedge clk_i);
      rst_i = 1'b0;
      flush_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("sat%0d_valid", i), 64'(valid_o), 64'd0);
         cnt_check($sformatf("sat%0d_cnt", i), (i + 1 > 15) ? 15 : i + 1);
      end
      @(negedge clk_i);
      flush_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the hazard control-zeroing mux: it captures that mux's gated control bits plus the ID-stage operands and register addresses, and presents them to the EX stage one cycle later. It adds hold (stall), flush, a per-entry valid bit, and an optional bubble counter used for CPI measurement.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- ALUOP_W, 2, ALUOp field width
- CNT_W, 16, bubble counter width (used only with the macro below)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold all stored fields for this cycle
- flush_i  in  1  replace entry with an all-zero bubble
- bubble_i  in  1  hazard flag from the hazard detection unit; marks the incoming entry as not valid
- RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, MemRead_i  in  1 each  control bits (already gated upstream)
- ALUOp_i  in  ALUOP_W  ALU operation class
- RSdata_i, RTdata_i, SignExt_i  in  DATA_W  operands, sign-extended immediate
- RSaddr_i, RTaddr_i, RDaddr_i  in  5  register specifiers
- *_o  out  same widths as matching *_i  registered copies of every field above
- valid_o  out  1  entry holds a real instruction
- bubble_cnt_o  out  CNT_W  bubbles inserted (present only with IDEX_BUBBLE_CNT_EN)

## Operation
- Per-edge priority: rst_i > flush_i > stall_i > load.
- Load, bubble_i=0: every *_o <= *_i; valid_o <= 1.
- Load, bubble_i=1: all control outputs (RegDst, ALUSrc, RegWrite, MemToReg, MemWrite, MemRead, ALUOp) <= 0 regardless of inputs; data/address fields load normally; valid_o <= 0.
- Stall: every field and valid_o hold. bubble_i is ignored.
- Flush: every field, including data and addresses, <= 0; valid_o <= 0. flush_i with stall_i: flush wins.
- Invariant: valid_o=0 implies RegWrite_o=MemWrite_o=MemRead_o=0.
- Bubble counter, macro on:
  - Increments by 1 on each edge where the entry is replaced by a non-valid entry: flush_i=1, or a load with bubble_i=1.
  - Stall cycles do not count.
  - Saturates at 2^CNT_W-1; no wrap.

## Timing
- Latency 1 cycle, input to output; no combinational path from any input to any output.
- Reset: on rst_i rise, all outputs go to 0 immediately (asynchronous), including valid_o and bubble_cnt_o. They stay 0 while rst_i is high.
- Release: the first load occurs on the first rising edge with rst_i low.
- Reset mid-stall: the held entry is lost; the register restarts empty.
- Back-to-back loads: throughput 1 entry per cycle.
- Stall lasting N cycles: outputs are constant for N edges; the next non-stalled edge loads the then-current inputs.

## Configuration
- Macro IDEX_BUBBLE_CNT_EN.
- Defined: bubble counter and bubble_cnt_o port exist, behaving as above.
- Undefined: no counter flops and no bubble_cnt_o port; all other behaviour is identical.

## Test plan
- Reset: assert rst_i between edges with outputs nonzero -> all outputs 0 before next edge; release, load RSdata_i=0x12345678, RegWrite_i=1 -> next edge RSdata_o=0x12345678, RegWrite_o=1, valid_o=1.
- Bubble: bubble_i=1 with RegWrite_i=MemWrite_i=1, ALUOp_i=2'b10, RTdata_i=0xDEADBEEF -> RegWrite_o=MemWrite_o=0, ALUOp_o=0, RTdata_o=0xDEADBEEF, valid_o=0, bubble_cnt_o +1.
- Stall: load entry A, then stall_i=1 for 3 cycles with differing inputs -> outputs equal A for all 3; the edge after stall_i drops loads current inputs; bubble_cnt_o unchanged.
- Flush beats stall: stall_i=1 and flush_i=1 same cycle with valid entry held -> all outputs 0, valid_o=0, bubble_cnt_o +1.
- Saturation (macro on, CNT_W=4): 20 consecutive flush cycles -> bubble_cnt_o reaches 15 and stays 15.
- Macro off build: same stimulus as the bubble scenario -> identical field outputs; elaboration shows no bubble_cnt_o port.
